// File: rtl/apb_pic_loader_if.sv
// APB bus bundle for the picture loader.
// Carries the APB3 completer-side signals: address, write data, control
// strobes (PSEL/PENABLE/PWRITE) and the response (PRDATA/PREADY/PSLVERR).
// The slave modport is used by apb_pic_loader; the master modport by
// whatever drives the bus (CPU bridge or testbench).
interface apb_pic_loader_if;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_pic_loader.sv
// apb_pic_loader
// Buffers 32-bit picture words written by the CPU over APB in a small FIFO
// and streams them to the conv engine as bytes (LSB byte of each word first)
// with a valid/ready handshake once the engine raises need_pic_i.
//
// Ports:
//   HCLK, HRESETn     clock and asynchronous active-low reset
//   apb (slave)       APB register port: CTRL/STATUS 0x00, DATA 0x04,
//                     LEN 0x08, REMAIN 0x0C; zero wait states
//   irq_o             level interrupt, done & irq_en
//   need_pic_i        conv engine requests a picture
//   pix_data_o        pixel byte
//   pix_valid_o       pixel valid
//   pix_ready_i       consumer ready
//   pix_last_o        final pixel of the frame, qualified by pix_valid_o
module apb_pic_loader #(
    parameter int DEPTH = 16,
    parameter int LEN_W = 16
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    apb_pic_loader_if.slave    apb,
    output logic               irq_o,
    input  logic               need_pic_i,
    output logic [7:0]         pix_data_o,
    output logic               pix_valid_o,
    input  logic               pix_ready_i,
    output logic               pix_last_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_REQ, STREAM, DONE} state_t;

    state_t             state_q, state_d;

    logic [31:0]        mem [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        count_q;
    logic               fifo_full, fifo_empty;

    logic [31:0]        word_q;
    logic [1:0]         idx_q;
    logic               unpack_valid_q;

    logic [LEN_W-1:0]   len_q, remain_q;
    logic               done_q, irq_en_q;

    logic               apb_wr, apb_rd;
    logic [1:0]         reg_sel;
    logic               ctrl_wr, data_wr, len_wr;
    logic               soft_clear, start, done_w1c;
    logic               hs, last_beat, need_load, pop, push;
    logic [7:0]         level8;
    logic               unused_addr_bits;

    // APB decode: only PADDR[3:2] select a register.
    assign apb_wr     = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign apb_rd     = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
    assign reg_sel    = apb.PADDR[3:2];
    assign ctrl_wr    = apb_wr & (reg_sel == 2'd0);
    assign data_wr    = apb_wr & (reg_sel == 2'd1);
    assign len_wr     = apb_wr & (reg_sel == 2'd2);
    assign unused_addr_bits = ^{apb.PADDR[31:4], apb.PADDR[1:0]};

    assign soft_clear = ctrl_wr & apb.PWDATA[2];
    assign done_w1c   = ctrl_wr & apb.PWDATA[3];
    assign start      = ctrl_wr & apb.PWDATA[0] & ~soft_clear &
                        (state_q == IDLE) & (len_q != '0);

    assign fifo_full  = (count_q == (AW+1)'(DEPTH));
    assign fifo_empty = (count_q == '0);

    // Stream handshake and word refill. A refill happens either when the
    // unpack register is empty, or on the handshake of byte 3 so the next
    // word's byte 0 follows with no bubble. The frame's final byte never
    // refills: remaining FIFO words belong to the next frame.
    assign hs        = unpack_valid_q & pix_ready_i & (state_q == STREAM);
    assign last_beat = (remain_q == LEN_W'(1));
    assign need_load = (state_q == STREAM) &
                       (~unpack_valid_q | (hs & (idx_q == 2'd3) & ~last_beat));
    assign pop       = need_load & ~fifo_empty & ~soft_clear;

    // A push into a full FIFO still succeeds if a pop frees a slot the same cycle.
    assign push        = data_wr & (~fifo_full | pop);
    assign apb.PSLVERR = data_wr & fifo_full & ~pop;
    assign apb.PREADY  = 1'b1;

    assign level8 = 8'(count_q);

    // FSM state register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM next-state logic; soft_clear overrides everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start)            state_d = WAIT_REQ;
            WAIT_REQ: if (need_pic_i)       state_d = STREAM;
            STREAM:   if (hs && last_beat)  state_d = DONE;
            DONE:                           state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
        if (soft_clear) state_d = IDLE;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (soft_clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents need no reset since occupancy guards reads.
    always_ff @(posedge HCLK) begin
        if (push) mem[wr_ptr_q] <= apb.PWDATA;
    end

    // Unpack register: one word and the index of the byte being presented.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            word_q         <= '0;
            idx_q          <= '0;
            unpack_valid_q <= 1'b0;
        end else if (soft_clear || (hs && last_beat)) begin
            idx_q          <= '0;
            unpack_valid_q <= 1'b0;
        end else if (pop) begin
            word_q         <= mem[rd_ptr_q];
            idx_q          <= '0;
            unpack_valid_q <= 1'b1;
        end else if (hs) begin
            idx_q <= idx_q + 1'b1;
            if (idx_q == 2'd3) unpack_valid_q <= 1'b0;
        end
    end

    // Frame registers: LEN, pixels remaining, sticky done and irq enable.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            len_q    <= '0;
            remain_q <= '0;
            done_q   <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            if (len_wr && state_q == IDLE) len_q <= apb.PWDATA[LEN_W-1:0];
            if (ctrl_wr) irq_en_q <= apb.PWDATA[1];

            if (soft_clear)   remain_q <= '0;
            else if (start)   remain_q <= len_q;
            else if (hs)      remain_q <= remain_q - 1'b1;

            // Setting from DONE wins over a same-cycle write-one-to-clear.
            if (soft_clear)             done_q <= 1'b0;
            else if (state_q == DONE)   done_q <= 1'b1;
            else if (done_w1c)          done_q <= 1'b0;
        end
    end

    // APB read mux; reads 0 outside a read access phase.
    always_comb begin
        apb.PRDATA = '0;
        if (apb_rd) begin
            case (reg_sel)
                2'd0: apb.PRDATA = {16'h0, level8, 2'b00, irq_en_q, done_q,
                                    need_pic_i, fifo_empty, fifo_full,
                                    (state_q != IDLE)};
                2'd2: apb.PRDATA = 32'(len_q);
                2'd3: apb.PRDATA = 32'(remain_q);
                default: apb.PRDATA = '0;
            endcase
        end
    end

    assign pix_valid_o = unpack_valid_q;
    assign pix_data_o  = unpack_valid_q ? word_q[{idx_q, 3'b000} +: 8] : 8'h00;
    assign pix_last_o  = unpack_valid_q & last_beat;
    assign irq_o       = done_q & irq_en_q;

endmodule
